// File: rtl/uart_tx_ctrl_if.sv
// FIFO-read and frame-register handshake between the UART transmit sequencer
// and its neighbours.
//   fifo_empty : TX FIFO empty flag
//   fifo_rdata : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd    : one-cycle FIFO pop strobe
//   frame_load : one-cycle enable for the downstream frame register
//   frame      : assembled frame
// master = transmit sequencer side, slave = FIFO / frame register side.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FRAME_W = 12
) ();
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_rdata;
  logic               fifo_rd;
  logic               frame_load;
  logic [FRAME_W-1:0] frame;

  modport master (
    input  fifo_empty, fifo_rdata,
    output fifo_rd, frame_load, frame
  );

  modport slave (
    output fifo_empty, fifo_rdata,
    input  fifo_rd, frame_load, frame
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Transmit sequencer for the APB UART. Pops a byte from the TX FIFO, builds
// a frame (start, 5-8 data bits, optional parity, 1-2 stop bits, idle
// padding), strobes it into the frame register and shifts it out LSB-first
// on tx_o, one bit per baud tick.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   baud_tick_i          : one-cycle pulse per bit period
//   tx_en_i              : transmitter enable
//   cfg_dlen_i           : data length 00=5 .. 11=8 bits
//   cfg_par_en_i         : parity enable
//   cfg_par_odd_i        : 1=odd, 0=even parity
//   cfg_stop2_i          : 1=two stop bits
//   bus                  : FIFO read / frame load handshake (master side)
//   tx_o                 : serial line
//   busy_o               : frame in progress
//   done_o               : one-cycle pulse when a frame completes
module uart_tx_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FRAME_W = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 baud_tick_i,
  input  logic                 tx_en_i,
  input  logic [1:0]           cfg_dlen_i,
  input  logic                 cfg_par_en_i,
  input  logic                 cfg_par_odd_i,
  input  logic                 cfg_stop2_i,
  uart_tx_ctrl_if.master       bus,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, shift_q, frame_d;
  logic [3:0]         cnt_q, n_q, n_d, dlen;
  logic               load_q, tx_q, rd_req, done, pop_ok, par_bit;

  assign pop_ok = tx_en_i & ~bus.fifo_empty;
  assign dlen   = {2'b00, cfg_dlen_i} + 4'd5;
  // Frame length: start + data + parity + stop bits.
  assign n_d    = dlen + 4'd2 + {3'b000, cfg_par_en_i} + {3'b000, cfg_stop2_i};

  // Frame image: start bit 0, data LSB first, parity right after the data,
  // everything above (stop bits and padding) left at 1.
  always_comb begin
    frame_d    = '1;
    par_bit    = cfg_par_odd_i;
    frame_d[0] = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < 32'(dlen)) begin
        frame_d[i+1] = bus.fifo_rdata[i];
        par_bit      = par_bit ^ bus.fifo_rdata[i];
      end
    end
    for (int unsigned i = 0; i < FRAME_W; i++) begin
      if (cfg_par_en_i && (i == 32'(dlen) + 1)) frame_d[i] = par_bit;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_req  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop_ok) begin
          rd_req  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = SHIFT;
      SHIFT: begin
        // cnt==N on a tick: the last bit has been held a full period.
        if (baud_tick_i && (cnt_q == n_q)) begin
          done = 1'b1;
          if (pop_ok) begin
            rd_req  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      frame_q <= '1;
      shift_q <= '1;
      cnt_q   <= '0;
      n_q     <= '0;
      tx_q    <= 1'b1;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= (state_q == FETCH);
      unique case (state_q)
        FETCH: begin
          frame_q <= frame_d;
          shift_q <= frame_d;
          n_q     <= n_d;
          cnt_q   <= '0;
        end
        SHIFT: begin
          if (baud_tick_i) begin
            if (cnt_q < n_q) begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b1, shift_q[FRAME_W-1:1]};
              cnt_q   <= cnt_q + 4'd1;
            end else begin
              tx_q  <= 1'b1;
              cnt_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The pop request is combinational from IDLE; hold it off while reset is
  // asserted so no byte is consumed during reset.
  assign bus.fifo_rd    = rd_req & rst_ni;
  assign bus.frame_load = load_q;
  assign bus.frame      = frame_q;
  assign tx_o           = tx_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;
  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       baud_tick = 1'b0;
  logic       tx_en = 1'b0;
  logic [1:0] cfg_dlen = 2'b00;
  logic       cfg_par_en = 1'b0;
  logic       cfg_par_odd = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic       tx, busy, done;

  uart_tx_ctrl_if #(.DATA_W(8), .FRAME_W(12)) u_if ();

  uart_tx_ctrl #(.DATA_W(8), .FRAME_W(12)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .baud_tick_i   (baud_tick),
    .tx_en_i       (tx_en),
    .cfg_dlen_i    (cfg_dlen),
    .cfg_par_en_i  (cfg_par_en),
    .cfg_par_odd_i (cfg_par_odd),
    .cfg_stop2_i   (cfg_stop2),
    .bus           (u_if),
    .tx_o          (tx),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  int vec = 0, err = 0;
  int tick_en = 0, div = 0, tick_num = 0;

  // Baud tick: one clock wide every DIV clocks, changed just after posedge.
  always @(posedge clk) begin
    #2;
    if (tick_en == 0) begin
      baud_tick = 1'b0;
      div = 0;
    end else if (div == DIV - 1) begin
      div = 0;
      baud_tick = 1'b1;
      tick_num++;
    end else begin
      div++;
      baud_tick = 1'b0;
    end
  end

  // FIFO model: read data appears the cycle after the pop strobe.
  logic [7:0] fifo_q[$];
  int pushed = 0, popped = 0, bad_pops = 0;
  assign u_if.fifo_empty = (pushed == popped);

  always @(posedge clk) begin
    if (u_if.fifo_rd === 1'b1) begin
      if (fifo_q.size() > 0) begin
        u_if.fifo_rdata <= fifo_q.pop_front();
        popped <= popped + 1;
      end else begin
        bad_pops <= bad_pops + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    pushed++;
  endtask

  // Reference frame from the format rules: list of line bits, padded with 1.
  function automatic logic [11:0] model_frame(input logic [7:0] d, input logic [1:0] dl,
                                              input logic pe, input logic po, input logic s2,
                                              output int n);
    bit q[$];
    int ones = 0;
    int L = int'(dl) + 5;
    q.push_back(1'b0);
    for (int i = 0; i < L; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) q.push_back(((ones % 2) == 1) ^ po);
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    n = q.size();
    model_frame = '1;
    for (int i = 0; i < n; i++) model_frame[i] = q[i];
  endfunction

  // Follows one frame from load to done, checking frame_o and every line bit.
  task automatic run_frame(input string name, input logic [7:0] d, input int drop_k,
                           input int stop_k, input bit scramble,
                           output int first_tick, output int done_tick);
    logic [11:0] exp;
    logic        exp_bit, exp_rd;
    int          n, k;
    bit          found;
    exp = model_frame(d, cfg_dlen, cfg_par_en, cfg_par_odd, cfg_stop2, n);
    first_tick = -1;
    done_tick  = -1;
    found      = 0;
    exp_rd     = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (u_if.frame_load === 1'b1) begin
        found = 1;
        break;
      end
    end
    vec++;
    if (!found) begin
      err++;
      $display("FAIL %s load_timeout: frame_load_o stayed low, required a pulse within 400 cycles", name);
      return;
    end
    vec++;
    if (u_if.frame !== exp) begin
      err++;
      $display("FAIL %s frame_o: got %h, required %h", name, u_if.frame, exp);
    end
    vec++;
    if (busy !== 1'b1) begin
      err++;
      $display("FAIL %s busy_at_load: got %b, required 1", name, busy);
    end
    if (scramble) begin
      cfg_dlen    = 2'($urandom);
      cfg_par_en  = 1'($urandom);
      cfg_par_odd = 1'($urandom);
      cfg_stop2   = 1'($urandom);
    end
    k = 0;
    for (int c = 0; c < (n + 3) * DIV * 2; c++) begin
      if (c > 0) @(negedge clk);
      if (baud_tick) begin
        k++;
        if (k == 1) first_tick = tick_num;
        exp_bit = (k == 1) ? 1'b1 : exp[k-2];
        vec++;
        if (tx !== exp_bit) begin
          err++;
          $display("FAIL %s tx_o before tick %0d: got %b, required %b", name, k, tx, exp_bit);
        end
        vec++;
        if (done !== (k == n + 1)) begin
          err++;
          $display("FAIL %s done_o at tick %0d: got %b, required %b", name, k, done, (k == n + 1));
        end
        if (k == n + 1) begin
          exp_rd = tx_en && (fifo_q.size() > 0);
          vec++;
          if (u_if.fifo_rd !== exp_rd) begin
            err++;
            $display("FAIL %s fifo_rd_at_done: got %b, required %b", name, u_if.fifo_rd, exp_rd);
          end
          done_tick = tick_num;
          break;
        end
        if (k == drop_k) tx_en = 1'b0;
        if (k == stop_k) return;
      end else begin
        vec++;
        if (done !== 1'b0) begin
          err++;
          $display("FAIL %s done_o between ticks: got %b, required 0", name, done);
        end
      end
    end
    if (done_tick < 0) begin
      vec++;
      err++;
      $display("FAIL %s done_timeout: got %0d ticks, required done at tick %0d", name, k, n + 1);
      return;
    end
    if (!exp_rd) begin
      @(negedge clk);
      vec++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        err++;
        $display("FAIL %s idle_after_done: got busy=%b tx=%b, required busy=0 tx=1", name, busy, tx);
      end
    end
  endtask

  task automatic test_reset();
    int ft, dt;
    rst_ni = 1'b0;
    tx_en  = 1'b1;
    push(8'h3C);
    repeat (3) @(negedge clk);
    vec++;
    if (tx !== 1'b1 || busy !== 1'b0 || u_if.frame !== 12'hFFF) begin
      err++;
      $display("FAIL reset_state: got tx=%b busy=%b frame=%h, required 1 0 fff", tx, busy, u_if.frame);
    end
    vec++;
    if (u_if.fifo_rd !== 1'b0 || u_if.frame_load !== 1'b0 || done !== 1'b0) begin
      err++;
      $display("FAIL reset_strobes: got rd=%b load=%b done=%b, required 0 0 0",
               u_if.fifo_rd, u_if.frame_load, done);
    end
    rst_ni  = 1'b1;
    tick_en = 1;
    run_frame("post_reset", 8'h3C, 0, 0, 0, ft, dt);
    tx_en = 1'b0;
  endtask

  task automatic test_formats();
    logic [7:0] bytes[3] = '{8'hA5, 8'h07, 8'hFF};
    logic [1:0] dl[3]    = '{2'b11, 2'b11, 2'b00};
    logic       pe[3]    = '{1'b0, 1'b1, 1'b1};
    logic       po[3]    = '{1'b0, 1'b0, 1'b1};
    logic       s2[3]    = '{1'b0, 1'b1, 1'b0};
    string      nm[3]    = '{"8N1", "8E2", "5O1"};
    int ft, dt, p0;
    for (int i = 0; i < 3; i++) begin
      cfg_dlen = dl[i]; cfg_par_en = pe[i]; cfg_par_odd = po[i]; cfg_stop2 = s2[i];
      p0 = popped;
      push(bytes[i]);
      tx_en = 1'b1;
      run_frame(nm[i], bytes[i], 0, 0, 0, ft, dt);
      tx_en = 1'b0;
      vec++;
      if (popped !== p0 + 1) begin
        err++;
        $display("FAIL %s pop_count: got %0d, required %0d", nm[i], popped - p0, 1);
      end
    end
  endtask

  task automatic test_random();
    int ft, dt;
    logic [7:0] b;
    for (int i = 0; i < 24; i++) begin
      cfg_dlen    = 2'($urandom);
      cfg_par_en  = 1'($urandom);
      cfg_par_odd = 1'($urandom);
      cfg_stop2   = 1'($urandom);
      b = 8'($urandom);
      push(b);
      tx_en = 1'b1;
      run_frame("random", b, 0, 0, 1, ft, dt);
    end
    tx_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ft1, dt1, ft2, dt2;
    cfg_dlen = 2'b11; cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
    push(8'h55);
    push(8'h0F);
    tx_en = 1'b1;
    run_frame("b2b_first", 8'h55, 0, 0, 0, ft1, dt1);
    run_frame("b2b_second", 8'h0F, 0, 0, 0, ft2, dt2);
    tx_en = 1'b0;
    vec++;
    if (ft2 !== dt1 + 1) begin
      err++;
      $display("FAIL b2b_gap: got %0d ticks from done to start bit, required 1", ft2 - dt1);
    end
  endtask

  task automatic test_gating();
    int ticks, ft, dt, p0;
    logic [7:0] b1, b2;
    tx_en = 1'b1;
    ticks = 0;
    for (int c = 0; c < 50 * DIV + 20 && ticks < 50; c++) begin
      @(negedge clk);
      if (baud_tick) begin
        ticks++;
        vec++;
        if (u_if.fifo_rd !== 1'b0 || tx !== 1'b1) begin
          err++;
          $display("FAIL empty_gate: got rd=%b tx=%b, required rd=0 tx=1", u_if.fifo_rd, tx);
        end
      end
    end
    vec++;
    if (ticks != 50) begin
      err++;
      $display("FAIL empty_gate_ticks: got %0d, required 50", ticks);
    end
    tx_en = 1'b0;
    cfg_dlen    = 2'($urandom);
    cfg_par_en  = 1'($urandom);
    cfg_par_odd = 1'($urandom);
    cfg_stop2   = 1'($urandom);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    push(b1);
    push(b2);
    tx_en = 1'b1;
    run_frame("en_drop", b1, 5, 0, 0, ft, dt);
    p0 = popped;
    repeat (20 * DIV) @(negedge clk);
    vec++;
    if (popped !== p0 || busy !== 1'b0) begin
      err++;
      $display("FAIL en_drop_no_pop: got pops=%0d busy=%b, required pops=0 busy=0", popped - p0, busy);
    end
    tx_en = 1'b1;
    run_frame("en_resume", b2, 0, 0, 0, ft, dt);
    tx_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ft, dt;
    logic [7:0] b;
    cfg_dlen = 2'b11; cfg_par_en = 1'b1; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
    push(8'hC3);
    tx_en = 1'b1;
    run_frame("pre_reset", 8'hC3, 0, 7, 0, ft, dt);
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    vec++;
    if (tx !== 1'b1 || busy !== 1'b0 || u_if.frame !== 12'hFFF) begin
      err++;
      $display("FAIL mid_reset: got tx=%b busy=%b frame=%h, required 1 0 fff", tx, busy, u_if.frame);
    end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    b = 8'($urandom);
    push(b);
    run_frame("after_reset", b, 0, 0, 0, ft, dt);
    tx_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_formats();
    test_random();
    test_back_to_back();
    test_gating();
    test_reset_mid();
    repeat (4) @(negedge clk);
    vec++;
    if (bad_pops !== 0) begin
      err++;
      $display("FAIL pop_while_empty: got %0d, required 0", bad_pops);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit sequencer for the APB UART.
- Pops bytes from the TX FIFO and assembles a 12-bit UART frame (start, 5–8 data bits, optional parity, 1–2 stop bits, idle padding).
- Issues the load strobe for the downstream 12-bit frame register.
- Serialises the frame LSB-first on tx_o, one bit per baud tick.

Parameters:
- DATA_W, 8: maximum data bits per frame, and the FIFO read width.
- FRAME_W, 12: frame register width. Must equal DATA_W+4.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous, active-low
- baud_tick_i  in  1  one-clk_i-cycle pulse per bit period
- tx_en_i  in  1  transmitter enable
- cfg_dlen_i  in  2  data length: 00=5, 01=6, 10=7, 11=8 bits
- cfg_par_en_i  in  1  parity enable
- cfg_par_odd_i  in  1  1=odd parity, 0=even parity
- cfg_stop2_i  in  1  1=two stop bits, 0=one stop bit
- fifo_empty_i  in  1  TX FIFO empty
- fifo_rdata_i  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_o
- fifo_rd_o  out  1  FIFO pop strobe, one cycle
- frame_load_o  out  1  frame register enable, one cycle
- frame_o  out  FRAME_W  assembled frame
- tx_o  out  1  serial line
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset values (asynchronous, any state, including mid-frame):
  - state=IDLE, tx_o=1, frame_o=12'hFFF, busy_o=0.
  - fifo_rd_o, frame_load_o, done_o all 0.
  - Bit counter and shift register cleared; shift register cleared to all ones.
- States: IDLE, FETCH, SHIFT.
- IDLE:
  - tx_o=1, busy_o=0.
  - If tx_en_i=1 and fifo_empty_i=0: assert fifo_rd_o for one cycle, go to FETCH.
  - baud_tick_i is ignored.
- FETCH (exactly one cycle):
  - Capture fifo_rdata_i and snapshot all cfg_* inputs.
  - Build the frame:
    - bit0=0 (start).
    - bits1..L = data[L-1:0], LSB first, where L=5..8.
    - Next bit = parity, if enabled: even = XOR of the L data bits; odd = its inverse.
    - Then 1 or 2 stop bits (=1).
    - All remaining upper bits = 1.
  - Frame length N = 1+L+par_en+(stop2?2:1). Range 7..12.
  - Load frame_o and the shift register; pulse frame_load_o; set busy_o=1; go to SHIFT.
  - Unused upper data bits are ignored.
  - A baud tick in FETCH is ignored.
- SHIFT (busy_o=1), on each baud_tick_i:
  - If cnt<N: tx_o <= shift[0]; shift right filling 1; cnt++.
  - If cnt==N: the last bit has held a full bit period. Pulse done_o, tx_o=1, cnt=0.
    - If tx_en_i=1 and fifo_empty_i=0: pulse fifo_rd_o the same cycle and go to FETCH.
    - Otherwise go to IDLE.
- Timing:
  - The start bit begins on the first tick after frame_load_o.
  - Each bit is held from its tick to the next tick.
  - Back-to-back frames are separated by exactly one idle (high) bit period.
- Config changes mid-frame have no effect until the next FETCH.
- tx_en_i deasserted mid-frame: the current frame completes normally; no new fetch.
- fifo_rd_o is never asserted while fifo_empty_i=1.
- frame_o holds its value between loads.
- Between ticks, all outputs are stable; the controller never acts on a tick-less cycle in SHIFT.
- Widths:
  - Internal counter is 4 bits and compares against N (≤12).
  - No arithmetic wrap occurs.

Test Plan:
- 8N1 (dlen=11, par_en=0, stop2=0), FIFO byte 0xA5:
  - fifo_rd_o pulse, then frame_load_o with frame_o=12'hF4A.
  - tx_o over successive ticks = 0,1,0,1,0,0,1,0,1,1.
  - done_o on the 11th tick after load; then IDLE with busy_o=0.
- 8E2 (dlen=11, par_en=1, par_odd=0, stop2=1), byte 0x07:
  - frame_o=12'hE0E, N=12, parity bit=1.
  - done_o on the 13th tick.
- 5O1 (dlen=00, par_en=1, par_odd=1), byte 0xFF:
  - Only 0x1F is used; frame_o=12'hFBE, N=8, parity bit=0.
  - tx_o = 0,1,1,1,1,1,0,1.
- Back-to-back: FIFO holds 0x55, 0x0F; tx_en_i held high:
  - Second fifo_rd_o occurs in the same cycle as the first done_o.
  - Exactly one high bit period separates the two frames.
- Gating:
  - tx_en_i=1 with fifo_empty_i=1 for 50 ticks → no fifo_rd_o, tx_o=1.
  - Clear tx_en_i during bit 4 of a frame → the frame completes, then no further pop.
- Reset mid-frame: assert rst_ni=0 during bit 6, between clock edges:
  - Immediately tx_o=1, busy_o=0, frame_o=12'hFFF.
  - After release, the next byte transmits from its start bit.
